// File: rtl/elevator_ctrl.sv
// Four-floor LOOK elevator controller: latches request pulses, travels, opens the door.
// Optional ELEV_DOOR_REOPEN_EN: a same-floor request during DOOR restarts the door timer.
module elevator_ctrl #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [1:0] floor,
    output logic       moving,
    output logic       door,
    output logic       direction
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      requests_q, requests_d;
    logic [1:0]      floor_q, floor_d;
    logic            dir_q, dir_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [3:0]      clr;
    logic [3:0]      above;
    logic [3:0]      below;
    logic [1:0]      next_floor;
    logic            door_restart;

    // Pending requests strictly above / below the car decide the LOOK direction.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < 4; i++) begin
            above[i] = requests_q[i] && (i > int'(floor_q));
            below[i] = requests_q[i] && (i < int'(floor_q));
        end
    end

    assign next_floor = dir_q ? floor_q + 2'd1 : floor_q - 2'd1;

`ifdef ELEV_DOOR_REOPEN_EN
    assign door_restart = req[floor_q];
`else
    assign door_restart = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        clr     = '0;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (requests_q[floor_q]) begin
                    state_d        = S_DOOR;
                    clr[floor_q]   = 1'b1;
                end else if (|above) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b1;
                end else if (|below) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b0;
                end
            end

            S_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    floor_d = next_floor;
                    timer_d = '0;
                    if (requests_q[next_floor]) begin
                        state_d         = S_DOOR;
                        clr[next_floor] = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DOOR: begin
                // Same-floor requests while the door is open are always absorbed.
                clr[floor_q] = 1'b1;
                if (door_restart) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        requests_d = (requests_q | req) & ~clr;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            requests_q <= '0;
            floor_q    <= 2'd0;
            dir_q      <= 1'b1;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            requests_q <= requests_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
        end
    end

    assign floor     = floor_q;
    assign moving    = (state_q == S_MOVE);
    assign door      = (state_q == S_DOOR);
    assign direction = dir_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: expected status changes are queued with their
// arrival cycle and compared by a monitor whenever the outputs change.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [1:0] floor;
    logic       moving;
    logic       door;
    logic       direction;

    elevator_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .floor     (floor),
        .moving    (moving),
        .door      (door),
        .direction (direction)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         at;
        logic [4:0] snap;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [4:0] snap;
    logic [4:0] last   = 5'b00001;
    int         e0;
    int         c_rst;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input string tag, input int at, input logic [1:0] f,
                           input logic m, input logic d, input logic dir);
        exp_t x;
        x.tag  = tag;
        x.at   = at;
        x.snap = {f, m, d, dir};
        sb.push_back(x);
    endtask

    task automatic pulse(input logic [3:0] r, output int edge0);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req   = 4'b0000;
        edge0 = cyc;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Snapshot is {floor, moving, door, direction}.
    always @(negedge clk) begin
        if (mon_en) begin
            snap = {floor, moving, door, direction};
            check("moving_door_exclusive", 32'(moving & door), 32'd0);
            if (snap !== last) begin
                check("change_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check($sformatf("%s_state", cur.tag), 32'(snap), 32'(cur.snap));
                    check($sformatf("%s_cycle", cur.tag), cyc, cur.at);
                end
                last = snap;
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_door", 32'(door), 32'd0);
        check("rst_direction", 32'(direction), 32'd1);
        check("rst_requests", 32'(dut.requests_q), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Up to 2, then down to 1.
        pulse(4'b0100, e0);
        push_ev("s1_depart", e0 + 1,  2'd0, 1, 0, 1);
        push_ev("s1_f1",     e0 + 5,  2'd1, 1, 0, 1);
        push_ev("s1_arr2",   e0 + 9,  2'd2, 0, 1, 1);
        push_ev("s1_close",  e0 + 12, 2'd2, 0, 0, 1);
        drain(40);
        pulse(4'b0010, e0);
        push_ev("s1_down",   e0 + 1,  2'd2, 1, 0, 0);
        push_ev("s1_arr1",   e0 + 5,  2'd1, 0, 1, 0);
        push_ev("s1_close1", e0 + 8,  2'd1, 0, 0, 0);
        drain(40);

        // Back to 0 to set up the two-stop upward trip.
        pulse(4'b0001, e0);
        push_ev("to0_depart", e0 + 1, 2'd1, 1, 0, 0);
        push_ev("to0_arr",    e0 + 5, 2'd0, 0, 1, 0);
        push_ev("to0_close",  e0 + 8, 2'd0, 0, 0, 0);
        drain(40);

        pulse(4'b1100, e0);
        push_ev("s2_depart", e0 + 1,  2'd0, 1, 0, 1);
        push_ev("s2_f1",     e0 + 5,  2'd1, 1, 0, 1);
        push_ev("s2_arr2",   e0 + 9,  2'd2, 0, 1, 1);
        push_ev("s2_close2", e0 + 12, 2'd2, 0, 0, 1);
        push_ev("s2_depart2",e0 + 13, 2'd2, 1, 0, 1);
        push_ev("s2_arr3",   e0 + 17, 2'd3, 0, 1, 1);
        push_ev("s2_close3", e0 + 20, 2'd3, 0, 0, 1);
        drain(60);
        check("s2_requests_empty", 32'(dut.requests_q), 32'd0);

        // From 3, two stops downward.
        pulse(4'b0011, e0);
        push_ev("s3_depart", e0 + 1,  2'd3, 1, 0, 0);
        push_ev("s3_f2",     e0 + 5,  2'd2, 1, 0, 0);
        push_ev("s3_arr1",   e0 + 9,  2'd1, 0, 1, 0);
        push_ev("s3_close1", e0 + 12, 2'd1, 0, 0, 0);
        push_ev("s3_depart2",e0 + 13, 2'd1, 1, 0, 0);
        push_ev("s3_arr0",   e0 + 17, 2'd0, 0, 1, 0);
        push_ev("s3_close0", e0 + 20, 2'd0, 0, 0, 0);
        drain(60);

        // Park at 1, then requests on both sides: above wins.
        pulse(4'b0010, e0);
        push_ev("to1_depart", e0 + 1, 2'd0, 1, 0, 1);
        push_ev("to1_arr",    e0 + 5, 2'd1, 0, 1, 1);
        push_ev("to1_close",  e0 + 8, 2'd1, 0, 0, 1);
        drain(40);
        pulse(4'b0101, e0);
        push_ev("s4_up",     e0 + 1,  2'd1, 1, 0, 1);
        push_ev("s4_arr2",   e0 + 5,  2'd2, 0, 1, 1);
        push_ev("s4_close2", e0 + 8,  2'd2, 0, 0, 1);
        push_ev("s4_down",   e0 + 9,  2'd2, 1, 0, 0);
        push_ev("s4_f1",     e0 + 13, 2'd1, 1, 0, 0);
        push_ev("s4_arr0",   e0 + 17, 2'd0, 0, 1, 0);
        push_ev("s4_close0", e0 + 20, 2'd0, 0, 0, 0);
        drain(60);

        // Request for the floor just left stays pending until the car reverses.
        pulse(4'b1000, e0);
        push_ev("s5_depart", e0 + 1,  2'd0, 1, 0, 1);
        push_ev("s5_f1",     e0 + 5,  2'd1, 1, 0, 1);
        push_ev("s5_f2",     e0 + 9,  2'd2, 1, 0, 1);
        push_ev("s5_arr3",   e0 + 13, 2'd3, 0, 1, 1);
        push_ev("s5_close3", e0 + 16, 2'd3, 0, 0, 1);
        push_ev("s5_return", e0 + 17, 2'd3, 1, 0, 0);
        push_ev("s5_f2b",    e0 + 21, 2'd2, 1, 0, 0);
        push_ev("s5_f1b",    e0 + 25, 2'd1, 1, 0, 0);
        push_ev("s5_arr0",   e0 + 29, 2'd0, 0, 1, 0);
        push_ev("s5_close0", e0 + 32, 2'd0, 0, 0, 0);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        check("s5_pending", 32'(dut.requests_q), 32'h9);
        drain(60);
        check("s5_requests_empty", 32'(dut.requests_q), 32'd0);

        // Reset while travelling between 1 and 2.
        pulse(4'b1000, e0);
        push_ev("s6_depart", e0 + 1, 2'd0, 1, 0, 1);
        push_ev("s6_f1",     e0 + 5, 2'd1, 1, 0, 1);
        drain(20);
        c_rst = cyc;
        push_ev("s6_reset", c_rst + 1, 2'd0, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        check("s6_rst_floor", 32'(floor), 32'd0);
        check("s6_rst_moving", 32'(moving), 32'd0);
        check("s6_rst_door", 32'(door), 32'd0);
        check("s6_rst_direction", 32'(direction), 32'd1);
        check("s6_rst_requests", 32'(dut.requests_q), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drain(5);

        // Same-floor request while the door is open is absorbed.
        pulse(4'b0001, e0);
        push_ev("s7_open", e0 + 1, 2'd0, 0, 1, 1);
`ifdef ELEV_DOOR_REOPEN_EN
        push_ev("s7_close", e0 + 5, 2'd0, 0, 0, 1);
`else
        push_ev("s7_close", e0 + 4, 2'd0, 0, 0, 1);
`endif
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        drain(20);
        check("s7_requests_empty", 32'(dut.requests_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
